// File: rtl/sat_corr_pkg.sv
// rtl/sat_corr_pkg.sv - shared widths, constants and FSM encoding for saturation correction
package sat_corr_pkg;

    localparam int GAIN_W   = 16;
    localparam int CHAN_W   = 16;
    localparam int FRAC_SUM = 23;
    localparam int OUT_W    = 8;
    localparam int PROD_W   = GAIN_W + CHAN_W;
    localparam int INT_W    = PROD_W - FRAC_SUM;

    localparam logic [GAIN_W-1:0] GAIN_ONE = 16'h2000;
    localparam logic [OUT_W-1:0]  SAT_MAX  = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_R = 3'd1,
        ST_MUL_G = 3'd2,
        ST_MUL_B = 3'd3,
        ST_OUT   = 3'd4
    } sat_state_e;

endpackage

// File: rtl/sat_corr_mult.sv
// rtl/sat_corr_mult.sv - Q3.13 x Q6.10 multiply, truncate to integer and clamp to 8 bits
module sat_corr_mult
    import sat_corr_pkg::*;
(
    input  logic [GAIN_W-1:0] gain,
    input  logic [CHAN_W-1:0] chan,
    output logic [OUT_W-1:0]  result,
    output logic              clipped
);

    logic [PROD_W-1:0] product;
    logic [INT_W-1:0]  int_part;

    assign product  = PROD_W'(gain) * PROD_W'(chan);
    assign int_part = product[PROD_W-1:FRAC_SUM];

    // Any set bit above the 8-bit range means the integer part exceeds 255.
    assign clipped = |int_part[INT_W-1:OUT_W];
    assign result  = clipped ? SAT_MAX : int_part[OUT_W-1:0];

endmodule

// File: rtl/sat_corr_scheduler.sv
// rtl/sat_corr_scheduler.sv - shares one multiplier over R/G/B; SATCORR_CLIP_COUNT_EN adds clip_count
module sat_corr_scheduler
    import sat_corr_pkg::*;
#(
    parameter logic [GAIN_W-1:0] GAIN_RESET = GAIN_ONE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gain_load,
    input  logic [GAIN_W-1:0] gain_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAN_W-1:0] in_r,
    input  logic [CHAN_W-1:0] in_g,
    input  logic [CHAN_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_r,
    output logic [OUT_W-1:0]  out_g,
    output logic [OUT_W-1:0]  out_b
`ifdef SATCORR_CLIP_COUNT_EN
    ,
    output logic [15:0]       clip_count
`endif
);

    localparam logic [2:0] IDLE  = ST_IDLE;
    localparam logic [2:0] MUL_R = ST_MUL_R;
    localparam logic [2:0] MUL_G = ST_MUL_G;
    localparam logic [2:0] MUL_B = ST_MUL_B;
    localparam logic [2:0] OUT   = ST_OUT;

    logic [2:0]        state;
    logic [GAIN_W-1:0] shadow_gain;
    logic [GAIN_W-1:0] work_gain;
    logic [CHAN_W-1:0] work_r;
    logic [CHAN_W-1:0] work_g;
    logic [CHAN_W-1:0] work_b;
    logic [CHAN_W-1:0] mul_chan;
    logic [OUT_W-1:0]  mul_result;
    logic              mul_clipped;
    logic              accept;

    assign in_ready  = (state == IDLE) | ((state == OUT) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == OUT);

    always_comb begin
        mul_chan = work_r;
        case (state)
            MUL_G:   mul_chan = work_g;
            MUL_B:   mul_chan = work_b;
            default: mul_chan = work_r;
        endcase
    end

    sat_corr_mult u_mult (
        .gain    (work_gain),
        .chan    (mul_chan),
        .result  (mul_result),
        .clipped (mul_clipped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow_gain <= GAIN_RESET;
            work_gain   <= GAIN_RESET;
            work_r      <= '0;
            work_g      <= '0;
            work_b      <= '0;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
        end else begin
            if (gain_load) begin
                shadow_gain <= gain_in;
            end
            // A load coinciding with accept applies to the accepted pixel.
            if (accept) begin
                work_r    <= in_r;
                work_g    <= in_g;
                work_b    <= in_b;
                work_gain <= gain_load ? gain_in : shadow_gain;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= MUL_R;
                    end
                end
                MUL_R: begin
                    out_r <= mul_result;
                    state <= MUL_G;
                end
                MUL_G: begin
                    out_g <= mul_result;
                    state <= MUL_B;
                end
                MUL_B: begin
                    out_b <= mul_result;
                    state <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state <= in_valid ? MUL_R : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SATCORR_CLIP_COUNT_EN
    logic clip_inc;

    assign clip_inc = mul_clipped & (state inside {MUL_R, MUL_G, MUL_B});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (gain_load) begin
            clip_count <= {15'd0, clip_inc};
        end else if (clip_inc && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`else
    logic unused_clipped;

    assign unused_clipped = mul_clipped;
`endif

endmodule

// File: tb/tb_sat_corr_scheduler.sv
// tb/tb_sat_corr_scheduler.sv - scoreboard bench for sat_corr_scheduler
module tb_sat_corr_scheduler;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         acc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        gain_load;
    logic [15:0] gain_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_r;
    logic [15:0] in_g;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_r;
    logic [7:0]  out_g;
    logic [7:0]  out_b;
`ifdef SATCORR_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    sat_corr_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gain_load  (gain_load),
        .gain_in    (gain_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b)
`ifdef SATCORR_CLIP_COUNT_EN
        ,
        .clip_count (clip_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Monitor: compares each presented result against the scoreboard head.
    bit presented = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            presented = 0;
        end else if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                if (!presented) chk("latency", cyc + 1 - sb[0].acc, 4);
                chk("out_r", out_r, sb[0].r);
                chk("out_g", out_g, sb[0].g);
                chk("out_b", out_b, sb[0].b);
                if (out_ready) begin
                    void'(sb.pop_front());
                    presented = 0;
                end else begin
                    presented = 1;
                end
            end
        end else begin
            presented = 0;
        end
    end

    task automatic send(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                        input bit ld, input logic [15:0] gv, output int acc);
        exp_t e;
        int n = 0;
        in_valid = 1'b1;
        in_r = r;
        in_g = g;
        in_b = b;
        acc = -1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (ld) begin
            gain_load = 1'b1;
            gain_in = gv;
        end
        acc = cyc + 1;
        e.r = er;
        e.g = eg;
        e.b = eb;
        e.acc = acc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        gain_load = 1'b0;
    endtask

    task automatic load(input logic [15:0] gv);
        gain_load = 1'b1;
        gain_in = gv;
        @(posedge clk);
        #1;
        gain_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                chk("drain_timeout", 0, 1);
                sb.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2;
        int n;
        rst_n = 1'b0;
        gain_load = 1'b0;
        gain_in = '0;
        in_valid = 1'b0;
        in_r = '0;
        in_g = '0;
        in_b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_g", out_g, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef SATCORR_CLIP_COUNT_EN
        chk("rst_clip_count", clip_count, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default gain 1.0
        send(16'hC800, 16'h2800, 16'h0200, 8'd50, 8'd10, 8'd0, 0, 16'h0, a0);
        drain();

        // Gain 2.0
        load(16'h4000);
        send(16'hC800, 16'h2800, 16'h0200, 8'd100, 8'd20, 8'd1, 0, 16'h0, a0);
        drain();

        // Gain 7.0, red clamps
        load(16'hE000);
        send(16'hC800, 16'h9000, 16'h5000, 8'd255, 8'd252, 8'd140, 0, 16'h0, a0);
        drain();
`ifdef SATCORR_CLIP_COUNT_EN
        chk("clip_count_one", clip_count, 1);
`endif

        // Load coincident with accept: pixel uses new 0.5 gain
        send(16'hC800, 16'h2800, 16'h0200, 8'd25, 8'd5, 8'd0, 1, 16'h1000, a0);
        drain();
`ifdef SATCORR_CLIP_COUNT_EN
        chk("clip_count_cleared", clip_count, 0);
`endif

        // Backpressure: hold OUT for 5 cycles, then retire and accept together
        out_ready = 1'b0;
        send(16'hC800, 16'h2800, 16'h0200, 8'd25, 8'd5, 8'd0, 0, 16'h0, a0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached_out", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'hC800, 16'h9000, 16'h5000, 8'd25, 8'd18, 8'd10, 0, 16'h0, a1);
        drain();

        // Back-to-back throughput
        send(16'h0400, 16'h0800, 16'h0C00, 8'd0, 8'd1, 8'd1, 0, 16'h0, a0);
        send(16'h1000, 16'h2000, 16'h4000, 8'd2, 8'd4, 8'd8, 0, 16'h0, a1);
        send(16'hFFFF, 16'h8000, 16'h0000, 8'd31, 8'd16, 8'd0, 0, 16'h0, a2);
        chk("throughput_1", a1 - a0, 4);
        chk("throughput_2", a2 - a1, 4);
        drain();

        // Gain change mid-pixel: A keeps 1.0, B takes 2.0
        load(16'h2000);
        send(16'hC800, 16'h2800, 16'h0200, 8'd50, 8'd10, 8'd0, 0, 16'h0, a0);
        @(posedge clk);
        #1;
        load(16'h4000);
        send(16'hC800, 16'h2800, 16'h0200, 8'd100, 8'd20, 8'd1, 0, 16'h0, a1);
        drain();

        // Reset during MUL_G discards the pixel and restores the reset gain
        send(16'hC800, 16'h2800, 16'h0200, 8'd100, 8'd20, 8'd1, 0, 16'h0, a0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_r", out_r, 0);
        chk("midrst_out_g", out_g, 0);
        chk("midrst_out_b", out_b, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale_out", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(16'hC800, 16'h2800, 16'h0200, 8'd50, 8'd10, 8'd0, 0, 16'h0, a0);
        drain();
`ifdef SATCORR_CLIP_COUNT_EN
        chk("clip_count_after_rst", clip_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
